// File: rtl/led_cmd_if.sv
// Command port of the LED pattern sequencer.
// A valid/ready channel that carries one reconfiguration request.
//   cmd_valid  : a command is present (master -> slave)
//   cmd_ready  : the sequencer can take a command (slave -> master)
//   cmd_mode   : 0=OFF, 1=CHASE, 2=BOUNCE, 3=BLINK_ALL
//   cmd_period : step length in clk cycles
//   cmd_on     : lit cycles at the start of each step
interface led_cmd_if #(
  parameter int CNT_W = 24
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_period;
  logic [CNT_W-1:0] cmd_on;

  modport master (
    output cmd_valid, cmd_mode, cmd_period, cmd_on,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_period, cmd_on,
    output cmd_ready
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: drives the LED bank with chase, bounce, blink-all
// or off patterns. Each step lasts `period` cycles; LEDs are lit for the
// first `on` cycles of a step. New configurations arriving mid-step are
// held in a shadow register and applied at the next step boundary so the
// LED output never changes pattern in the middle of a step.
//   clk         : system clock, rising edge
//   rst         : synchronous, active-high reset
//   cmd         : command port (led_cmd_if slave)
//   leds        : registered LED drive, bit i = LED i, 1 = lit
//   step_strobe : registered one-cycle pulse after each step end
//   busy        : registered, high while the active mode is not OFF
module led_pattern_sequencer #(
  parameter int NUM_LEDS       = 6,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 1200000
) (
  input  logic                clk,
  input  logic                rst,
  led_cmd_if.slave            cmd,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_strobe,
  output logic                busy
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2);

  typedef enum logic [1:0] {M_OFF, M_CHASE, M_BOUNCE, M_BLINK} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PENDING} state_e;

  state_e             state, state_n;
  mode_e              mode, mode_n, sh_mode, sh_mode_n;
  logic [CNT_W-1:0]   period, period_n, on_time, on_n;
  logic [CNT_W-1:0]   sh_period, sh_period_n, sh_on, sh_on_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic               dir_down, dir_down_n;
  logic [NUM_LEDS-1:0] leds_n, pattern;
  logic               strobe_n, busy_n;

  logic               hs, step_end;
  mode_e              src_mode;
  logic [CNT_W-1:0]   src_period, src_on, cmd_period_cl;

  assign cmd.cmd_ready = (state != S_PENDING);
  assign hs            = cmd.cmd_valid & cmd.cmd_ready;
  assign step_end      = (state != S_IDLE) && (cnt == period - CNT_ONE);
  // Periods below 2 would make every cycle a boundary; clamp at capture.
  assign cmd_period_cl = (cmd.cmd_period < MIN_PER) ? MIN_PER : cmd.cmd_period;

  // At a boundary a pending shadow wins; otherwise a same-cycle command
  // is applied directly without passing through PENDING.
  assign src_mode   = (state == S_PENDING) ? sh_mode   : mode_e'(cmd.cmd_mode);
  assign src_period = (state == S_PENDING) ? sh_period : cmd_period_cl;
  assign src_on     = (state == S_PENDING) ? sh_on     : cmd.cmd_on;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would infer a latch; blocking '=' is correct here.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    period_n    = period;
    on_n        = on_time;
    cnt_n       = cnt;
    pos_n       = pos;
    dir_down_n  = dir_down;
    sh_mode_n   = sh_mode;
    sh_period_n = sh_period;
    sh_on_n     = sh_on;
    strobe_n    = 1'b0;

    case (state)
      S_IDLE: begin
        if (hs) begin
          period_n = cmd_period_cl;
          on_n     = cmd.cmd_on;
          if (mode_e'(cmd.cmd_mode) != M_OFF) begin
            mode_n     = mode_e'(cmd.cmd_mode);
            cnt_n      = '0;
            pos_n      = '0;
            dir_down_n = 1'b0;
            state_n    = S_RUN;
          end
        end
      end
      default: begin
        if (step_end) begin
          cnt_n    = '0;
          strobe_n = 1'b1;
          if (state == S_PENDING || hs) begin
            mode_n     = src_mode;
            period_n   = src_period;
            on_n       = src_on;
            pos_n      = '0;
            dir_down_n = 1'b0;
            state_n    = (src_mode == M_OFF) ? S_IDLE : S_RUN;
          end else if (NUM_LEDS > 1) begin
            case (mode)
              M_CHASE: pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
              M_BOUNCE: begin
                if (!dir_down) begin
                  if (pos == POS_LAST) begin
                    dir_down_n = 1'b1;
                    pos_n      = POS_LAST - 1'b1;
                  end else begin
                    pos_n = pos + 1'b1;
                  end
                end else begin
                  if (pos == '0) begin
                    dir_down_n = 1'b0;
                    pos_n      = POS_W'(1);
                  end else begin
                    pos_n = pos - 1'b1;
                  end
                end
              end
              default: pos_n = pos;
            endcase
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
          if (hs) begin
            sh_mode_n   = mode_e'(cmd.cmd_mode);
            sh_period_n = cmd_period_cl;
            sh_on_n     = cmd.cmd_on;
            state_n     = S_PENDING;
          end
        end
      end
    endcase

    pattern = '0;
    case (mode)
      M_CHASE, M_BOUNCE: pattern[pos] = 1'b1;
      M_BLINK:           pattern      = '1;
      default:           pattern      = '0;
    endcase
    leds_n = (cnt < on_time) ? pattern : '0;
    busy_n = (mode_n != M_OFF);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values; all of them, shadow included, are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode        <= M_OFF;
      period      <= CNT_W'(DEFAULT_PERIOD);
      on_time     <= CNT_W'(DEFAULT_PERIOD / 2);
      cnt         <= '0;
      pos         <= '0;
      dir_down    <= 1'b0;
      sh_mode     <= M_OFF;
      sh_period   <= MIN_PER;
      sh_on       <= '0;
      leds        <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      mode        <= mode_n;
      period      <= period_n;
      on_time     <= on_n;
      cnt         <= cnt_n;
      pos         <= pos_n;
      dir_down    <= dir_down_n;
      sh_mode     <= sh_mode_n;
      sh_period   <= sh_period_n;
      sh_on       <= sh_on_n;
      leds        <= leds_n;
      step_strobe <= strobe_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: table-driven pattern runs
// for CHASE and BOUNCE plus directed sequences for deferred commands,
// same-cycle boundary commands, period clamping, OFF while running and
// reset with a command pending.
module tb_led_pattern_sequencer;
  localparam int N = 6;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] leds;
  logic         step_strobe;
  logic         busy;

  always #5 clk = ~clk;

  led_cmd_if #(.CNT_W(W)) bus ();

  led_pattern_sequencer #(
    .NUM_LEDS(N), .CNT_W(W), .DEFAULT_PERIOD(1200000)
  ) dut (
    .clk(clk), .rst(rst), .cmd(bus),
    .leds(leds), .step_strobe(step_strobe), .busy(busy)
  );

  typedef struct {
    logic [N-1:0] leds;
    logic         strobe;
  } vec_t;

  vec_t chase_v[28];
  vec_t bounce_v[24];
  int   bounce_seq[12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] p, input logic [W-1:0] o);
    bus.cmd_valid  = v;
    bus.cmd_mode   = m;
    bus.cmd_period = p;
    bus.cmd_on     = o;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, '0, '0);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Drive one command for a single edge (IDLE accepts it there).
  task automatic accept(input logic [1:0] m, input logic [W-1:0] p, input logic [W-1:0] o);
    drive(1'b1, m, p, o);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
  endtask

  initial begin
    int idle_bad;

    // Expected tables. Entry i is sampled after the (i+1)-th edge past accept.
    for (int i = 0; i < 28; i++) begin
      chase_v[i].leds   = ((i % 4) < 2) ? (N'(1) << ((i / 4) % N)) : '0;
      chase_v[i].strobe = ((i % 4) == 3);
    end
    for (int i = 0; i < 24; i++) begin
      bounce_v[i].leds   = N'(1) << bounce_seq[i / 2];
      bounce_v[i].strobe = ((i % 2) == 1);
    end

    // Reset state and idle hold.
    do_reset();
    check("rst_leds", leds, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_strobe", step_strobe, 0);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (leds !== '0 || busy !== 1'b0) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    // CHASE period=4 on=2, including wrap from LED5 to LED0.
    accept(2'd1, 24'd4, 24'd2);
    check("chase_busy", busy, 1);
    check("chase_first_leds", leds, 0);
    for (int i = 0; i < 28; i++) begin
      cyc();
      check($sformatf("chase_leds[%0d]", i), leds, chase_v[i].leds);
      check($sformatf("chase_strobe[%0d]", i), step_strobe, chase_v[i].strobe);
    end

    // BOUNCE period=2 on=2.
    do_reset();
    accept(2'd2, 24'd2, 24'd2);
    for (int i = 0; i < 24; i++) begin
      cyc();
      check($sformatf("bounce_leds[%0d]", i), leds, bounce_v[i].leds);
      check($sformatf("bounce_strobe[%0d]", i), step_strobe, bounce_v[i].strobe);
    end

    // Deferred command: CHASE period 8, send BLINK_ALL at cnt=3.
    do_reset();
    accept(2'd1, 24'd8, 24'd8);
    cyc(); cyc(); cyc();
    drive(1'b1, 2'd3, 24'd4, 24'd4);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("defer_ready_low[%0d]", i), bus.cmd_ready, 0);
      check($sformatf("defer_old_leds[%0d]", i), leds, 6'b000001);
      if (i < 3) cyc();
    end
    cyc();
    check("defer_ready_back", bus.cmd_ready, 1);
    check("defer_bound_strobe", step_strobe, 1);
    check("defer_bound_leds", leds, 6'b000001);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check($sformatf("defer_blink_leds[%0d]", i), leds, 6'b111111);
      check($sformatf("defer_blink_strobe[%0d]", i), step_strobe, (i % 4) == 3);
    end

    // Same-cycle boundary command with period=0 (clamped to 2), then OFF.
    do_reset();
    accept(2'd1, 24'd4, 24'd4);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("bnd_ready_pre[%0d]", i), bus.cmd_ready, 1);
    end
    drive(1'b1, 2'd3, 24'd0, 24'd1);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    check("bnd_ready", bus.cmd_ready, 1);
    check("bnd_strobe", step_strobe, 1);
    check("bnd_leds", leds, 6'b000001);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("clamp_leds[%0d]", i), leds, ((i % 2) == 0) ? 6'b111111 : 6'b000000);
      check($sformatf("clamp_strobe[%0d]", i), step_strobe, (i % 2) == 1);
      check($sformatf("clamp_ready[%0d]", i), bus.cmd_ready, 1);
    end
    drive(1'b1, 2'd0, 24'd2, 24'd1);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    check("off_pending_ready", bus.cmd_ready, 0);
    check("off_pending_busy", busy, 1);
    cyc();
    check("off_applied_busy", busy, 0);
    check("off_applied_ready", bus.cmd_ready, 1);
    check("off_applied_strobe", step_strobe, 1);
    check("off_applied_leds", leds, 0);
    cyc();
    check("off_after_leds", leds, 0);
    check("off_after_strobe", step_strobe, 0);

    // Reset while PENDING at cnt=5 discards the shadow.
    do_reset();
    accept(2'd1, 24'd8, 24'd8);
    drive(1'b1, 2'd3, 24'd4, 24'd4);
    cyc();
    drive(1'b0, 2'd0, '0, '0);
    cyc(); cyc(); cyc(); cyc();
    check("midrst_pending", bus.cmd_ready, 0);
    check("midrst_busy_pre", busy, 1);
    rst = 1'b1;
    cyc();
    check("midrst_leds", leds, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", bus.cmd_ready, 1);
    check("midrst_strobe", step_strobe, 0);
    rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (leds !== '0 || busy !== 1'b0 || step_strobe !== 1'b0) idle_bad++;
    end
    check("midrst_shadow_discarded", idle_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
